// File: rtl/sequence_checker.sv
// sequence_checker: stores the Simon Says sequence and grades each player symbol against it.
// Latency: 1 cycle from in_valid to correct/wrong/round_done; timeout fires TIMEOUT_CYC cycles after busy rises.
// Backpressure: none; every in_valid strobe in WAIT_IN is graded, strobes in any other state are dropped.
module sequence_checker #(
  parameter int MAX_LEN     = 16,
  parameter int SYM_W       = 4,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seq_load,
  input  logic [SYM_W-1:0] seq_sym,
  input  logic             round_start,
  input  logic [LEN_W-1:0] round_len,
  input  logic             in_valid,
  input  logic [SYM_W-1:0] in_sym,
  output logic [LEN_W-1:0] seq_count,
  output logic             busy,
  output logic [LEN_W-1:0] idx,
  output logic             correct,
  output logic             wrong,
  output logic             timed_out,
  output logic             round_done,
  output logic             game_over
);

  // Memory address width; idx and seq_count carry one extra bit so they can hold MAX_LEN itself.
  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN_L    = LEN_W'(MAX_LEN);
  localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_IN = 2'd1;
  localparam logic [1:0] ST_FAIL    = 2'd2;

  logic [1:0]       state;
  logic [SYM_W-1:0] mem [MAX_LEN];
  logic [LEN_W-1:0] len_q;
  logic [31:0]      tmo_cnt;

  logic             in_wait;
  logic             load_ok;
  logic             start_ok;
  logic [SYM_W-1:0] exp_sym;
  logic             sym_hit;
  logic             sym_miss;
  logic             tmo_fire;
  logic             last_sym;

  // Decode this cycle's events. round_start is judged against the pre-load seq_count,
  // and in_sym only takes part in a compare when in_valid qualifies it.
  always_comb begin
    in_wait  = (state == ST_WAIT_IN);
    load_ok  = (state == ST_IDLE) && seq_load && (seq_count < MAX_LEN_L);
    start_ok = (state == ST_IDLE) && round_start &&
               (round_len != '0) && (round_len <= seq_count);
    exp_sym  = mem[idx[ADDR_W-1:0]];
    sym_hit  = in_wait && in_valid && (in_sym == exp_sym);
    sym_miss = in_wait && in_valid && (in_sym != exp_sym);
    tmo_fire = in_wait && !in_valid && (tmo_cnt == TIMEOUT_LAST);
    last_sym = ((idx + LEN_W'(1)) == len_q);
  end

  // Sequence memory: append-only in IDLE, loads beyond MAX_LEN are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_count <= '0;
      for (int i = 0; i < MAX_LEN; i++) mem[i] <= '0;
    end else if (load_ok) begin
      mem[seq_count[ADDR_W-1:0]] <= seq_sym;
      seq_count                  <= seq_count + LEN_W'(1);
    end
  end

  // Control FSM: IDLE -> WAIT_IN on a legal round_start, back on round completion, FAIL is terminal.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (start_ok) state <= ST_WAIT_IN;
        ST_WAIT_IN: begin
          if (sym_miss || tmo_fire)     state <= ST_FAIL;
          else if (sym_hit && last_sym) state <= ST_IDLE;
        end
        ST_FAIL:    state <= ST_FAIL;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Round position: cleared on start and on completion, advanced on each matched symbol, held on a miss.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx   <= '0;
      len_q <= '0;
    end else if (start_ok) begin
      idx   <= '0;
      len_q <= round_len;
    end else if (sym_hit) begin
      idx <= last_sym ? '0 : idx + LEN_W'(1);
    end
  end

  // Idle-cycle counter; any graded input restarts it, and it stops at the expiry value.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (start_ok) begin
      tmo_cnt <= '0;
    end else if (in_wait) begin
      if (in_valid)                      tmo_cnt <= '0;
      else if (tmo_cnt != TIMEOUT_LAST)  tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  // Result pulses last one cycle; timed_out stays set until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      correct    <= 1'b0;
      wrong      <= 1'b0;
      round_done <= 1'b0;
      timed_out  <= 1'b0;
    end else begin
      correct    <= sym_hit;
      wrong      <= sym_miss || tmo_fire;
      round_done <= sym_hit && last_sym;
      if (tmo_fire) timed_out <= 1'b1;
    end
  end

  assign busy      = (state == ST_WAIT_IN);
  assign game_over = (state == ST_FAIL);

endmodule

// File: tb/tb_sequence_checker.sv
// Bench for sequence_checker: scoreboard of expected result pulses, one entry per graded input.
// Inputs driven at negedge, outputs sampled at the following negedge.
// Strobes are auto-cleared just after each rising edge so every strobe lasts one cycle.
module tb_sequence_checker;

  localparam int MAX_LEN     = 16;
  localparam int SYM_W       = 4;
  localparam int TIMEOUT_CYC = 8;
  localparam int LEN_W       = $clog2(MAX_LEN + 1);

  typedef struct packed {
    logic c;
    logic w;
    logic d;
  } res_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             seq_load = 1'b0;
  logic [SYM_W-1:0] seq_sym = '0;
  logic             round_start = 1'b0;
  logic [LEN_W-1:0] round_len = '0;
  logic             in_valid = 1'b0;
  logic [SYM_W-1:0] in_sym = '0;
  logic [LEN_W-1:0] seq_count;
  logic             busy;
  logic [LEN_W-1:0] idx;
  logic             correct;
  logic             wrong;
  logic             timed_out;
  logic             round_done;
  logic             game_over;

  res_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  sequence_checker #(
    .MAX_LEN(MAX_LEN), .SYM_W(SYM_W), .TIMEOUT_CYC(TIMEOUT_CYC), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .reset(reset), .seq_load(seq_load), .seq_sym(seq_sym),
    .round_start(round_start), .round_len(round_len), .in_valid(in_valid), .in_sym(in_sym),
    .seq_count(seq_count), .busy(busy), .idx(idx), .correct(correct), .wrong(wrong),
    .timed_out(timed_out), .round_done(round_done), .game_over(game_over)
  );

  // One clock; the scoreboard entry due this cycle (or "no pulse") is popped and compared.
  task automatic step();
    res_t exp_r;
    res_t act_r;
    @(posedge clk);
    #1;
    seq_load    = 1'b0;
    round_start = 1'b0;
    in_valid    = 1'b0;
    @(negedge clk);
    exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : res_t'(3'b000);
    act_r = {correct, wrong, round_done};
    checks++;
    if (act_r !== exp_r) begin
      fails++;
      $display("FAIL pulses @%0t: correct/wrong/round_done got %b required %b", $time, act_r, exp_r);
    end
  endtask

  task automatic do_reset();
    exp_q.delete();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic load(input logic [SYM_W-1:0] s);
    seq_load = 1'b1;
    seq_sym  = s;
    step();
  endtask

  task automatic start(input int n);
    round_start = 1'b1;
    round_len   = LEN_W'(n);
    step();
  endtask

  task automatic send(input logic [SYM_W-1:0] s, input res_t r);
    exp_q.push_back(r);
    in_valid = 1'b1;
    in_sym   = s;
    step();
  endtask

  task automatic test_reset();
    logic [SYM_W-1:0] syms [3];
    syms = '{4'd3, 4'd5, 4'd9};
    do_reset();
    checks++;
    if ({seq_count, idx, busy, timed_out, game_over} !== '0) begin
      fails++;
      $display("FAIL reset_state: cnt=%0d idx=%0d busy=%b to=%b go=%b required all 0",
               seq_count, idx, busy, timed_out, game_over);
    end
    load(4'd3);
    load(4'd5);
    // load together with round_start: start judged against count 2, so rejected
    seq_load = 1'b1; seq_sym = 4'd9; round_start = 1'b1; round_len = 3;
    step();
    checks++;
    if (busy !== 1'b0 || seq_count !== 3) begin
      fails++;
      $display("FAIL load_with_start: busy=%b cnt=%0d required busy=0 cnt=3", busy, seq_count);
    end
    start(3);
    checks++;
    if (busy !== 1'b1 || idx !== 0) begin
      fails++;
      $display("FAIL round_start: busy=%b idx=%0d required 1 0", busy, idx);
    end
    for (int i = 0; i < 3; i++) begin
      send(syms[i], '{1'b1, 1'b0, i == 2});
      checks++;
      if (idx !== LEN_W'((i + 1) % 3) || busy !== (i < 2)) begin
        fails++;
        $display("FAIL round_progress[%0d]: idx=%0d busy=%b required idx=%0d busy=%b",
                 i, idx, busy, (i + 1) % 3, i < 2);
      end
    end
  endtask

  task automatic test_mismatch();
    start(2);
    send(4'd3, '{1'b1, 1'b0, 1'b0});
    send(4'd7, '{1'b0, 1'b1, 1'b0});
    checks++;
    if (game_over !== 1'b1 || timed_out !== 1'b0 || busy !== 1'b0 || idx !== 1) begin
      fails++;
      $display("FAIL mismatch_state: go=%b to=%b busy=%b idx=%0d required 1 0 0 1",
               game_over, timed_out, busy, idx);
    end
    start(2);
    send(4'd5, '{1'b0, 1'b0, 1'b0});
    checks++;
    if (game_over !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL fail_terminal: go=%b busy=%b required 1 0", game_over, busy);
    end
  endtask

  task automatic load_359();
    load(4'd3);
    load(4'd5);
    load(4'd9);
  endtask

  task automatic test_timeout();
    do_reset();
    load_359();
    start(1);
    for (int i = 1; i < TIMEOUT_CYC; i++) step();
    checks++;
    if (timed_out !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL timeout_early: to=%b busy=%b required 0 1", timed_out, busy);
    end
    exp_q.push_back('{1'b0, 1'b1, 1'b0});
    step();
    checks++;
    if (timed_out !== 1'b1 || game_over !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_fire: to=%b go=%b busy=%b required 1 1 0", timed_out, game_over, busy);
    end
    // correct symbol in the expiry cycle beats the timeout
    do_reset();
    load_359();
    start(2);
    for (int i = 1; i < TIMEOUT_CYC; i++) step();
    send(4'd3, '{1'b1, 1'b0, 1'b0});
    checks++;
    if (timed_out !== 1'b0 || game_over !== 1'b0 || busy !== 1'b1 || idx !== 1) begin
      fails++;
      $display("FAIL timeout_race: to=%b go=%b busy=%b idx=%0d required 0 0 1 1",
               timed_out, game_over, busy, idx);
    end
    for (int i = 1; i < TIMEOUT_CYC; i++) step();
    send(4'd5, '{1'b1, 1'b0, 1'b1});
    checks++;
    if (timed_out !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_restart: to=%b busy=%b required 0 0", timed_out, busy);
    end
  endtask

  task automatic test_bounds();
    logic [SYM_W-1:0] model [MAX_LEN];
    do_reset();
    load_359();
    start(0);
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL len_zero: busy=%b required 0", busy);
    end
    start(4);
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL len_over: busy=%b required 0", busy);
    end
    do_reset();
    for (int i = 0; i < MAX_LEN + 1; i++) begin
      if (i < MAX_LEN) model[i] = SYM_W'((i * 7 + 3) % 16);
      load(SYM_W'((i * 7 + 3) % 16));
    end
    checks++;
    if (seq_count !== MAX_LEN) begin
      fails++;
      $display("FAIL mem_full: cnt=%0d required %0d", seq_count, MAX_LEN);
    end
    start(MAX_LEN);
    for (int i = 0; i < MAX_LEN; i++) send(model[i], '{1'b1, 1'b0, i == MAX_LEN - 1});
    checks++;
    if (busy !== 1'b0 || idx !== 0) begin
      fails++;
      $display("FAIL full_round: busy=%b idx=%0d required 0 0", busy, idx);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_359();
    start(3);
    send(4'd3, '{1'b1, 1'b0, 1'b0});
    exp_q.delete();
    reset = 1'b1; in_valid = 1'b1; in_sym = 4'd5;
    step();
    reset = 1'b0;
    checks++;
    if ({seq_count, idx, busy, timed_out, game_over} !== '0) begin
      fails++;
      $display("FAIL reset_mid: cnt=%0d idx=%0d busy=%b to=%b go=%b required all 0",
               seq_count, idx, busy, timed_out, game_over);
    end
    send(4'd0, '{1'b0, 1'b0, 1'b0});
    checks++;
    if (busy !== 1'b0 || idx !== 0) begin
      fails++;
      $display("FAIL stray_input: busy=%b idx=%0d required 0 0", busy, idx);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 4; i++) load(SYM_W'(i));
    start(4);
    for (int i = 1; i <= 4; i++) send(SYM_W'(i), '{1'b1, 1'b0, i == 4});
    checks++;
    if (busy !== 1'b0 || idx !== 0 || game_over !== 1'b0) begin
      fails++;
      $display("FAIL back_to_back_end: busy=%b idx=%0d go=%b required 0 0 0", busy, idx, game_over);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mismatch();
    test_timeout();
    test_bounds();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
